// File: rtl/inst_encoder.sv
// RV32IM field-level instruction encoder with legality check and output FIFO.
// Requests are encoded combinationally and captured straight into the FIFO on accept.
module inst_encoder #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_class,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic        in_f7b5,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_err,
   output logic [7:0]  err_count,
   output logic [15:0] inst_count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [3:0] {
      CLS_R      = 4'd0,
      CLS_I      = 4'd1,
      CLS_BRANCH = 4'd2,
      CLS_LOAD   = 4'd3,
      CLS_STORE  = 4'd4,
      CLS_JALR   = 4'd5,
      CLS_JAL    = 4'd6,
      CLS_AUIPC  = 4'd7,
      CLS_LUI    = 4'd8,
      CLS_RMUL   = 4'd9,
      CLS_ECALL  = 4'd10,
      CLS_EBREAK = 4'd11,
      CLS_FENCE  = 4'd12
   } cls_e;

   cls_e        cls;
   logic [31:0] enc_inst;
   logic        legal;
   logic        i_ok, b_ok, j_ok, u_ok, sh_ok, is_shift;

   logic [32:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop;

   always_comb begin
      cls      = cls_e'(in_class);
      i_ok     = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
      b_ok     = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
      j_ok     = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];
      u_ok     = (in_imm[11:0] == '0);
      sh_ok    = (in_imm[31:5] == '0);
      is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
      enc_inst = '0;
      legal    = 1'b0;
      case (cls)
         CLS_R: begin
            enc_inst = {1'b0, in_f7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            legal    = 1'b1;
         end
         CLS_RMUL: begin
            enc_inst = {7'b0000001, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            legal    = 1'b1;
         end
         CLS_I: begin
            if (is_shift) begin
               enc_inst = {1'b0, in_f7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
               legal    = sh_ok;
            end else begin
               enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
               legal    = i_ok;
            end
         end
         CLS_LOAD: begin
            enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            legal    = i_ok;
         end
         CLS_STORE: begin
            enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            legal    = i_ok;
         end
         CLS_BRANCH: begin
            enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], 7'b1100011};
            legal    = b_ok;
         end
         CLS_JALR: begin
            enc_inst = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            legal    = i_ok;
         end
         CLS_JAL: begin
            enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            legal    = j_ok;
         end
         CLS_AUIPC: begin
            enc_inst = {in_imm[31:12], in_rd, 7'b0010111};
            legal    = u_ok;
         end
         CLS_LUI: begin
            enc_inst = {in_imm[31:12], in_rd, 7'b0110111};
            legal    = u_ok;
         end
         CLS_ECALL: begin
            enc_inst = 32'h0000_0073;
            legal    = 1'b1;
         end
         CLS_EBREAK: begin
            enc_inst = 32'h0010_0073;
            legal    = 1'b1;
         end
         CLS_FENCE: begin
            enc_inst = 32'h0FF0_000F;
            legal    = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      // Illegal requests are replaced by a canonical NOP (ADDI x0,x0,0)
      if (!legal) enc_inst = 32'h0000_0013;
   end

   assign in_ready  = (count < DEPTH_C);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_inst  = out_valid ? mem[rd_ptr][31:0] : '0;
   assign out_err   = out_valid ? mem[rd_ptr][32] : 1'b0;

   // Storage carries no reset; emptiness is tracked solely by count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {~legal, enc_inst};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         err_count  <= '0;
         inst_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) begin
            rd_ptr     <= rd_ptr + PW'(1);
            inst_count <= inst_count + 16'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (push && !legal && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus randomized traffic
// compared against an arithmetic encoding model and a queue-based FIFO model.
module tb_inst_encoder;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_class;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic        in_f7b5;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;
   logic [7:0]  err_count;
   logic [15:0] inst_count;

   int checks   = 0;
   int failures = 0;

   logic [32:0] q[$];
   int          m_ecnt;
   int          m_icnt;

   inst_encoder #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_err(out_err), .err_count(err_count), .inst_count(inst_count)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
      return (v >> lo) % (32'd1 << (hi - lo + 1));
   endfunction

   // Reference encoder built from field arithmetic and signed range tests.
   function automatic logic [32:0] ref_enc(input int cls, input int rd, input int rs1,
                                           input int rs2, input int f3, input int f7b5,
                                           input logic [31:0] u);
      int          s;
      logic        ok;
      logic [31:0] w;
      s  = signed'(u);
      ok = 1'b1;
      w  = 0;
      case (cls)
         0: w = f7b5 * 2**30 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h33;
         9: w = 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h33;
         1: begin
            if (f3 == 1 || f3 == 5) begin
               ok = (u < 32);
               w  = f7b5 * 2**30 + fld(u, 4, 0) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h13;
            end else begin
               ok = (s >= -2048 && s <= 2047);
               w  = fld(u, 11, 0) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h13;
            end
         end
         3: begin
            ok = (s >= -2048 && s <= 2047);
            w  = fld(u, 11, 0) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h03;
         end
         4: begin
            ok = (s >= -2048 && s <= 2047);
            w  = fld(u, 11, 5) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + fld(u, 4, 0) * 2**7 + 'h23;
         end
         2: begin
            ok = (s >= -4096 && s <= 4095 && (s % 2) == 0);
            w  = fld(u, 12, 12) * 2**31 + fld(u, 10, 5) * 2**25 + rs2 * 2**20 + rs1 * 2**15
               + f3 * 2**12 + fld(u, 4, 1) * 2**8 + fld(u, 11, 11) * 2**7 + 'h63;
         end
         5: begin
            ok = (s >= -2048 && s <= 2047);
            w  = fld(u, 11, 0) * 2**20 + rs1 * 2**15 + rd * 2**7 + 'h67;
         end
         6: begin
            ok = (s >= -(2**20) && s < 2**20 && (s % 2) == 0);
            w  = fld(u, 20, 20) * 2**31 + fld(u, 10, 1) * 2**21 + fld(u, 11, 11) * 2**20
               + fld(u, 19, 12) * 2**12 + rd * 2**7 + 'h6F;
         end
         7, 8: begin
            ok = (u % 4096 == 0);
            w  = (u / 4096) * 4096 + rd * 2**7 + ((cls == 7) ? 'h17 : 'h37);
         end
         10: w = 32'h0000_0073;
         11: w = 32'h0010_0073;
         12: w = 32'h0FF0_000F;
         default: ok = 1'b0;
      endcase
      if (!ok) w = 32'h0000_0013;
      return {~ok, w};
   endfunction

   // Check visible state against the model, then advance one clock and update the model.
   task automatic cycle();
      bit          push, pop;
      logic [32:0] e;
      chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("out_inst", out_inst, (q.size() != 0) ? q[0][31:0] : 32'h0);
      chk("out_err", {31'b0, out_err}, {31'b0, (q.size() != 0) ? q[0][32] : 1'b0});
      chk("err_count", {24'b0, err_count}, m_ecnt);
      chk("inst_count", {16'b0, inst_count}, m_icnt);
      push = in_valid && (q.size() < DEPTH);
      pop  = (q.size() != 0) && out_ready;
      e    = ref_enc(in_class, in_rd, in_rs1, in_rs2, in_funct3, in_f7b5, in_imm);
      @(posedge clk);
      #1;
      if (pop) begin
         void'(q.pop_front());
         m_icnt = (m_icnt + 1) % 65536;
      end
      if (push) begin
         q.push_back(e);
         if (e[32] && m_ecnt < 255) m_ecnt++;
      end
   endtask

   task automatic set_req(input int cls, input int rd, input int rs1, input int rs2,
                          input int f3, input int f7b5, input logic [31:0] imm);
      in_class  = 4'(cls);
      in_rd     = 5'(rd);
      in_rs1    = 5'(rs1);
      in_rs2    = 5'(rs2);
      in_funct3 = 3'(f3);
      in_f7b5   = 1'(f7b5);
      in_imm    = imm;
   endtask

   task automatic push_req(input int cls, input int rd, input int rs1, input int rs2,
                           input int f3, input int f7b5, input logic [31:0] imm);
      set_req(cls, rd, rs1, rs2, f3, f7b5, imm);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic model_reset();
      q.delete();
      m_ecnt = 0;
      m_icnt = 0;
   endtask

   task automatic rand_req();
      logic [31:0] imm;
      case ($urandom_range(0, 3))
         0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
         1: imm = $urandom;
         2: imm = $urandom & 32'hFFFF_F000;
         default: imm = 32'($urandom_range(0, 40));
      endcase
      set_req($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 1), imm);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      set_req(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);

      // Directed encodings
      push_req(1, 1, 0, 0, 0, 0, 32'd5);
      chk("addi", out_inst, 32'h0050_0093);
      chk("addi_err", {31'b0, out_err}, 32'd0);
      cycle();
      chk("addi_icnt", {16'b0, inst_count}, 32'd1);
      push_req(0, 3, 1, 2, 0, 1, 32'd0);
      chk("sub", out_inst, 32'h4020_81B3);
      push_req(2, 0, 1, 2, 0, 0, 32'd8);
      chk("beq", out_inst, 32'h0020_8463);
      push_req(10, 7, 7, 7, 7, 1, 32'hFFFF_FFFF);
      chk("ecall", out_inst, 32'h0000_0073);

      // Illegal requests
      push_req(2, 0, 1, 2, 0, 0, 32'd7);
      chk("beq_odd", out_inst, 32'h0000_0013);
      chk("beq_odd_err", {31'b0, out_err}, 32'd1);
      push_req(14, 1, 1, 1, 0, 0, 32'd0);
      chk("cls14", out_inst, 32'h0000_0013);
      chk("cls14_err", {31'b0, out_err}, 32'd1);
      cycle();
      chk("err_cnt2", {24'b0, err_count}, 32'd2);
      set_req(14, 0, 0, 0, 0, 0, 0);
      in_valid = 1'b1;
      repeat (300) cycle();
      in_valid = 1'b0;
      repeat (2) cycle();
      chk("err_sat", {24'b0, err_count}, 32'd255);

      // Backpressure: A, B fill the FIFO, C is held
      out_ready = 1'b0;
      push_req(0, 5, 6, 7, 0, 0, 0);
      push_req(9, 8, 9, 10, 4, 0, 0);
      chk("full_ready", {31'b0, in_ready}, 32'd0);
      set_req(8, 11, 0, 0, 0, 0, 32'h1234_5000);
      in_valid = 1'b1;
      repeat (2) cycle();
      out_ready = 1'b1;
      chk("bp_head_a", out_inst, 32'h0073_02B3);
      repeat (2) cycle();
      in_valid = 1'b0;
      chk("bp_head_c", out_inst, 32'h1234_55B7);
      repeat (2) cycle();

      // Concurrent push/pop holds occupancy at one
      out_ready = 1'b0;
      push_req(3, 1, 2, 0, 2, 0, 32'hFFFF_FFFC);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int unsigned i = 0; i < 10; i++) begin
         set_req(1, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0, 0,
                 32'($urandom_range(0, 2047)));
         cycle();
         chk("pp_valid", {31'b0, out_valid}, 32'd1);
         chk("pp_ready", {31'b0, in_ready}, 32'd1);
      end
      in_valid = 1'b0;
      repeat (2) cycle();

      // Asynchronous reset with two entries queued and err_count = 3
      model_reset();
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      push_req(13, 0, 0, 0, 0, 0, 0);
      cycle();
      out_ready = 1'b0;
      push_req(15, 0, 0, 0, 0, 0, 0);
      push_req(4, 0, 0, 0, 0, 0, 32'h0000_1000);
      chk("pre_rst_ecnt", {24'b0, err_count}, 32'd3);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_inst", out_inst, 32'd0);
      chk("arst_err", {31'b0, out_err}, 32'd0);
      chk("arst_ecnt", {24'b0, err_count}, 32'd0);
      chk("arst_icnt", {16'b0, inst_count}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      chk("arst_ready", {31'b0, in_ready}, 32'd1);

      // Randomized traffic
      for (int unsigned i = 0; i < 600; i++) begin
         rand_req();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
